// File: rtl/mem_arbiter.sv
// Two-port arbiter (fetch/data) sequencing phy_mem reads and edge-triggered writes; read ack at grant+READ_CYCLES+1, write ack at grant+WRITE_CYCLES+2.
// Ports stall while waiting; define ARB_ROUND_ROBIN_EN for alternating grant on contention, otherwise the data port always wins.
module mem_arbiter #(
   parameter int READ_CYCLES  = 2,
   parameter int WRITE_CYCLES = 4
) (
   input  logic        i_clk50M,
   input  logic        i_rst,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_ack,
   output logic [31:0] o_if_rdata,
   output logic        o_if_stall,
   input  logic        i_mem_req,
   input  logic        i_mem_we,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   output logic        o_mem_ack,
   output logic [31:0] o_mem_rdata,
   output logic        o_mem_stall,
   output logic        o_phy_is_write,
   output logic [31:0] o_phy_addr,
   output logic [31:0] o_phy_wdata,
   input  logic [31:0] i_phy_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_GAP,
      S_ACK
   } state_t;

   localparam logic [2:0] LP_RD_CNT = 3'(READ_CYCLES);
   localparam logic [2:0] LP_WR_CNT = 3'(WRITE_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_cnt;
   logic        r_owner;      // 1 = data port; doubles as last-grant bit
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_mem_rdata;
   logic        w_any_req;
   logic        w_grant_mem;

   assign w_any_req = i_if_req | i_mem_req;

`ifdef ARB_ROUND_ROBIN_EN
   assign w_grant_mem = i_mem_req & (~i_if_req | ~r_owner);
`else
   assign w_grant_mem = i_mem_req;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_next = (w_grant_mem & i_mem_we) ? S_WR : S_RD;
            end
         end
         S_RD: begin
            if (r_cnt == LP_RD_CNT) begin
               w_next = S_ACK;
            end
         end
         S_WR: begin
            if (r_cnt == LP_WR_CNT) begin
               w_next = S_GAP;
            end
         end
         S_GAP:   w_next = S_ACK;
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk50M or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_if_rdata  <= 32'd0;
         r_mem_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) begin
            r_cnt <= 3'd1;
         end else begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (r_state == S_IDLE && w_any_req) begin
            r_owner <= w_grant_mem;
            r_we    <= w_grant_mem & i_mem_we;
            r_addr  <= w_grant_mem ? i_mem_addr : i_if_addr;
            if (w_grant_mem) begin
               r_wdata <= i_mem_wdata;
            end
         end
         if (r_state == S_RD && r_cnt == LP_RD_CNT) begin
            if (r_owner) begin
               r_mem_rdata <= i_phy_rdata;
            end else begin
               r_if_rdata <= i_phy_rdata;
            end
         end
      end
   end

   assign o_phy_is_write = (r_state == S_WR);
   assign o_phy_addr     = r_addr;
   assign o_phy_wdata    = r_wdata;
   assign o_if_ack       = (r_state == S_ACK) & ~r_owner;
   assign o_mem_ack      = (r_state == S_ACK) & r_owner;
   assign o_if_rdata     = r_if_rdata;
   assign o_mem_rdata    = r_mem_rdata;
   // Gated by reset so every output reads 0 while reset is held.
   assign o_if_stall     = i_rst & i_if_req & ~o_if_ack;
   assign o_mem_stall    = i_rst & i_mem_req & ~o_mem_ack;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single physical memory controller (phy_mem) between the CPU instruction-fetch port and data-access port. It sits between the pipeline's IF/MEM stages and phy_mem, serialises requests, sequences phy_mem's read latency and its edge-triggered write protocol (is_write rising edge, write pulse, recovery), and returns read data with a one-cycle acknowledge. Stall outputs hold the pipeline while a port waits.

## Interface
- READ_CYCLES, 2, cycles address is held before read data is captured (min 2)
- WRITE_CYCLES, 4, cycles is_write is held high per write (covers phy_mem write + recovery, min 4)
- clk50M  input  1  system clock, all arbiter state on rising edge
- rst  input  1  asynchronous reset, active low
- if_req  input  1  fetch request, level, held until if_ack
- if_addr  input  32  fetch address, stable while if_req
- if_ack  output  1  one-cycle pulse, if_rdata valid this cycle
- if_rdata  output  32  fetch read data (registered)
- if_stall  output  1  if_req high and if_ack low
- mem_req  input  1  data request, level, held until mem_ack
- mem_we  input  1  1 = write, 0 = read; stable while mem_req
- mem_addr  input  32  data address
- mem_wdata  input  32  write data
- mem_ack  output  1  one-cycle completion pulse
- mem_rdata  output  32  data read result (registered)
- mem_stall  output  1  mem_req high and mem_ack low
- phy_is_write  output  1  to phy_mem is_write
- phy_addr  output  32  to phy_mem addr_in
- phy_wdata  output  32  to phy_mem data_in
- phy_rdata  input  32  from phy_mem data_out

## Operation
- States: IDLE, RD (read wait), WR (write pulse), GAP (is_write low cycle), ACK.
- IDLE: if any request, latch grant owner, address, we, wdata into registers; phy_addr/phy_wdata driven from latches; go RD (read) or WR (write, mem port only). Fetch is always read.
- Arbitration: mem over if when both request in the same IDLE cycle.
- RD: counter from 1; when count == READ_CYCLES capture phy_rdata into owner's rdata register, go ACK.
- WR: phy_is_write = 1; counter from 1; at count == WRITE_CYCLES go GAP.
- GAP: phy_is_write = 0 one cycle, guarantees a fresh rising edge for the next write; go ACK.
- ACK: pulse owner's ack; go IDLE. The other port's pending request is taken in that IDLE cycle.
- Counter 3 bits, saturating not required; parameters limited to 2..7.
- Non-owner rdata registers unchanged by another port's transaction.
- Requests dropped mid-transaction are ignored; the transaction completes and acks anyway.

## Timing
- Reset values: all outputs 0, state IDLE, grant latch = fetch.
- Reset asserted mid-transaction: immediately IDLE, phy_is_write 0, no ack issued.
- Read latency: request seen in IDLE at edge N -> ack high during cycle N+READ_CYCLES+1 (4 cycles of 2 for default... i.e. ack at N+3).
- Write latency: ack at N+WRITE_CYCLES+2 (N+6 default); phy_is_write high exactly WRITE_CYCLES cycles.
- Back-to-back service: one IDLE cycle between transactions; minimum gap between two phy_is_write rises = WRITE_CYCLES+3.
- phy_addr/phy_wdata stable from IDLE exit until return to IDLE.
- Stalls are combinational from req and ack.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant goes to the port not granted last (last-grant bit updated on each grant); prevents fetch starvation under continuous data traffic.
- Undefined: fixed priority, mem port always wins.

## Test plan
- Reset: rst low with if_req=1 -> all outputs 0; release -> fetch read of 0x1FC00000 acks 3 cycles after grant, if_rdata = phy_rdata model value.
- Data write 0x00000010 <- 0xDEADBEEF -> phy_is_write high 4 cycles, phy_addr/phy_wdata stable, then low 1 cycle, mem_ack pulse; if_rdata unchanged.
- Two consecutive mem writes -> phy_is_write has low cycle between them, two rising edges, two acks.
- if_req and mem_req (read 0x1FD003FC) same cycle, fixed priority -> mem_ack first, if_ack next transaction; with ARB_ROUND_ROBIN_EN and last grant=mem -> if served first.
- Continuous mem_req with if_req held, ARB_ROUND_ROBIN_EN -> grants alternate mem/if; without macro if_stall stays high.
- rst asserted during WR count 2 -> phy_is_write drops immediately, no mem_ack, next request restarts cleanly.
